// File: rtl/sigmoid_pipe.sv
// Pipelined sigmoid: 16-segment piecewise-linear interpolation over |x| in [0,8),
// negative inputs mirrored through sigmoid(-x) = 1 - sigmoid(x).
// Three register stages, with a valid/ready handshake, tag pass-through and a
// saturating count of accepted inputs with |x| >= 8.0.
module sigmoid_pipe #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned IN_FRAC  = 8,
  parameter int unsigned OUT_FRAC = 8,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_x,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_FRAC:0]   out_y,
  output logic [TAG_W-1:0]    out_tag,
  input  logic                clear,
  output logic [CNT_W-1:0]    sat_cnt
);

  localparam int unsigned OUT_W = OUT_FRAC + 1;
  localparam int unsigned A_W   = IN_W + 1;
  localparam int unsigned F_W   = IN_FRAC - 1;
  localparam int unsigned P_W   = OUT_W + F_W;

  localparam logic [OUT_W-1:0] ONE     = {1'b1, {OUT_FRAC{1'b0}}};
  localparam logic [A_W-1:0]   SAT_LIM = A_W'(8 << IN_FRAC);

  // round(2^OUT_FRAC / (1 + e^(-k/2))) in 64-bit fixed point so the table is
  // built from integer constants at elaboration time.
  function automatic logic [OUT_W-1:0] tab_entry(input int unsigned k);
    longint term;
    longint q;
    longint ek;
    longint den;
    longint num;
    // e^(-1/2) in Q30 via Taylor series
    term = 64'sd1 <<< 30;
    q    = term;
    for (int n = 1; n < 20; n++) begin
      term = -term / longint'(2 * n);
      q    = q + term;
    end
    ek = 64'sd1 <<< 30;
    for (int unsigned i = 0; i < k; i++) begin
      ek = (ek * q) >>> 30;
    end
    den = (64'sd1 <<< 30) + ek;
    // 2^(OUT_FRAC+30) / den, rounded to nearest
    num = (64'sd1 <<< (OUT_FRAC + 31)) + den;
    return OUT_W'(num / (64'sd2 * den));
  endfunction

  logic [OUT_W-1:0] tab [17];

  for (genvar k = 0; k < 17; k++) begin : g_tab
    localparam logic [OUT_W-1:0] TabVal = tab_entry(k);
    assign tab[k] = TabVal;
  end

  // Whole pipe advances together; no bubble collapse.
  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && in_ready;

  // ---------------- S1 front end ----------------
  logic [A_W-1:0] x_ext;
  logic [A_W-1:0] a_abs;
  logic           sat_in;

  // One extra bit so |most negative input| does not overflow.
  assign x_ext  = {in_x[IN_W-1], in_x};
  assign a_abs  = in_x[IN_W-1] ? -x_ext : x_ext;
  assign sat_in = a_abs >= SAT_LIM;

  logic             s1_valid;
  logic             s1_sign;
  logic             s1_sat;
  logic [3:0]       s1_idx;
  logic [F_W-1:0]   s1_frac;
  logic [TAG_W-1:0] s1_tag;

  // Stage 1: sign, saturation flag, segment index (0.5 step) and fraction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sat   <= 1'b0;
      s1_idx   <= '0;
      s1_frac  <= '0;
      s1_tag   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= in_x[IN_W-1];
      s1_sat   <= sat_in;
      s1_idx   <= a_abs[IN_FRAC+2:IN_FRAC-1];
      s1_frac  <= a_abs[IN_FRAC-2:0];
      s1_tag   <= in_tag;
    end
  end

  // ---------------- S2 table fetch and slope product ----------------
  logic [4:0]       idx_nxt;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] diff;
  logic [P_W-1:0]   prod;

  // Table is monotone, so diff never underflows.
  assign idx_nxt = {1'b0, s1_idx} + 5'd1;
  assign base    = tab[s1_idx];
  assign diff    = tab[idx_nxt] - base;
  assign prod    = P_W'(diff) * P_W'(s1_frac);

  logic             s2_valid;
  logic             s2_sign;
  logic             s2_sat;
  logic [OUT_W-1:0] s2_base;
  logic [P_W-1:0]   s2_prod;
  logic [TAG_W-1:0] s2_tag;

  // Stage 2: register segment base and full-width slope*fraction product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_sat   <= 1'b0;
      s2_base  <= '0;
      s2_prod  <= '0;
      s2_tag   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_sat   <= s1_sat;
      s2_base  <= base;
      s2_prod  <= prod;
      s2_tag   <= s1_tag;
    end
  end

  // ---------------- S3 interpolate, saturate, mirror ----------------
  logic [OUT_W-1:0] m_interp;
  logic [OUT_W-1:0] m_val;
  logic [OUT_W-1:0] y_val;

  // Interpolated value stays within [T[idx], T[idx+1]], so no overflow.
  assign m_interp = s2_base + OUT_W'(s2_prod >> F_W);
  assign m_val    = s2_sat ? ONE : m_interp;
  assign y_val    = s2_sign ? (ONE - m_val) : m_val;

  // Stage 3: output register; holds while downstream is not ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_y     <= y_val;
      out_tag   <= s2_tag;
    end
  end

  // Saturation counter: counted on the accept cycle, sticks at all-ones, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt <= '0;
    end else if (clear) begin
      sat_cnt <= '0;
    end else if (accept && sat_in && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Self-checking bench for sigmoid_pipe: directed cases, random handshake traffic
// and a full input sweep, all scored against a behavioural model.
module tb_sigmoid_pipe;

  localparam int IN_W     = 16;
  localparam int IN_FRAC  = 8;
  localparam int OUT_FRAC = 8;
  localparam int TAG_W    = 4;
  localparam int CNT_W    = 16;

  localparam int ONE     = 1 << OUT_FRAC;
  localparam int STEP    = 1 << (IN_FRAC - 1);
  localparam int SAT_A   = 8 << IN_FRAC;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_W-1:0]     in_x = '0;
  logic [TAG_W-1:0]    in_tag = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [OUT_FRAC:0]   out_y;
  logic [TAG_W-1:0]    out_tag;
  logic                clear = 1'b0;
  logic [CNT_W-1:0]    sat_cnt;

  always #5 clk = ~clk;

  sigmoid_pipe #(
    .IN_W     (IN_W),
    .IN_FRAC  (IN_FRAC),
    .OUT_FRAC (OUT_FRAC),
    .TAG_W    (TAG_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .clear     (clear),
    .sat_cnt   (sat_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, got, got, exp, exp, $time);
  endtask

  // Reference table values for OUT_FRAC = 8.
  int tab [0:16] = '{128, 159, 187, 209, 225, 237, 244, 248, 251,
                     253, 254, 255, 255, 256, 256, 256, 256};

  function automatic int ref_sig(input int x);
    int a;
    int i;
    int f;
    int m;
    a = (x < 0) ? -x : x;
    if (a >= SAT_A) begin
      m = ONE;
    end else begin
      i = a / STEP;
      f = a % STEP;
      m = tab[i] + ((tab[i+1] - tab[i]) * f) / STEP;
    end
    return (x < 0) ? ONE - m : m;
  endfunction

  function automatic int ideal_sig(input int x);
    real r;
    r = real'(ONE) / (1.0 + $exp(-real'(x) / real'(1 << IN_FRAC)));
    return int'(r);
  endfunction

  typedef struct {
    int y;
    int tag;
    int acc;
    int x;
  } exp_t;

  exp_t sb[$];
  int   log_y[$];
  int   log_tag[$];
  int   log_lat[$];

  int cyc      = 0;
  int exp_cnt  = 0;
  bit hold_vld = 1'b0;
  int hold_y   = 0;
  int hold_tag = 0;
  bit sweep_on = 1'b0;
  int prev_y   = -1;

  always @(posedge clk) cyc++;

  // Monitor: samples mid-cycle, predicts what the next rising edge transfers.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   xs;
    int   diff;
    bit   acc;
    if (reset) begin
      exp_cnt  = 0;
      hold_vld = 1'b0;
    end else begin
      check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
      check("sat_cnt", int'(sat_cnt), exp_cnt);
      if (hold_vld) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_y", int'(out_y), hold_y);
        check("hold_tag", int'(out_tag), hold_tag);
      end
      hold_vld = out_valid && !out_ready;
      hold_y   = int'(out_y);
      hold_tag = int'(out_tag);
      if (out_valid && out_ready) begin
        check("out_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("y", int'(out_y), e.y);
          check("tag", int'(out_tag), e.tag);
          log_y.push_back(int'(out_y));
          log_tag.push_back(int'(out_tag));
          log_lat.push_back(cyc - e.acc);
          if (sweep_on) begin
            if (prev_y >= 0) check("monotone", int'(int'(out_y) >= prev_y), 1);
            prev_y = int'(out_y);
            diff = int'(out_y) - ideal_sig(e.x);
            if (diff < 0) diff = -diff;
            check("approx", int'(diff <= 2), 1);
          end
        end
      end
      xs  = int'($signed(in_x));
      acc = in_valid && in_ready;
      if (acc) sb.push_back('{y: ref_sig(xs), tag: int'(in_tag), acc: cyc, x: xs});
      if (clear) exp_cnt = 0;
      else if (acc && (xs >= SAT_A || xs <= -SAT_A) && exp_cnt < CNT_MAX) exp_cnt++;
    end
  end

  task automatic send(input int x, input int tag);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_x     = x[IN_W-1:0];
    in_tag   = tag[TAG_W-1:0];
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        check("accept_timeout", int'(in_ready), 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_log(input string tag, input int base, input int idx,
                           input int y, input int t, input int lat);
    if (log_y.size() > base + idx) begin
      check({tag, "_y"}, log_y[base+idx], y);
      check({tag, "_tag"}, log_tag[base+idx], t);
      if (lat >= 0) check({tag, "_lat"}, log_lat[base+idx], lat);
    end else begin
      check({tag, "_present"}, log_y.size(), base + idx + 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int base;
    int v;

    // Reset values
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_tag", int'(out_tag), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic stream, exact latency
    base = log_y.size();
    send('h0000, 1);
    send('h0100, 2);
    send('hFF00, 3);
    drain();
    check_log("t1a", base, 0, 'h080, 1, 3);
    check_log("t1b", base, 1, 'h0BB, 2, 3);
    check_log("t1c", base, 2, 'h045, 3, 3);

    // Interpolation truncation and mirroring
    base = log_y.size();
    send('h0040, 4);
    send('hFFC0, 5);
    drain();
    check_log("t2a", base, 0, 'h08F, 4, 3);
    check_log("t2b", base, 1, 'h071, 5, 3);

    // Saturation, counter, clear beats increment
    base = log_y.size();
    send('h0800, 6);
    send('h7FFF, 7);
    send('hF800, 8);
    send('h8000, 9);
    drain();
    check_log("t3a", base, 0, 'h100, 6, 3);
    check_log("t3b", base, 1, 'h100, 7, 3);
    check_log("t3c", base, 2, 'h000, 8, 3);
    check_log("t3d", base, 3, 'h000, 9, 3);
    check("sat_cnt_4", int'(sat_cnt), 4);
    clear = 1'b1;
    send('h0800, 10);
    clear = 1'b0;
    check("sat_cnt_clear", int'(sat_cnt), 0);
    drain();

    // Back-pressure
    base = log_y.size();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 65535)), i + 8);
      end
      begin
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", log_y.size() - base, 8);

    // Reset with samples in flight
    send('h0100, 1);
    send('h0200, 2);
    send('h0300, 3);
    reset = 1'b1;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_y", int'(out_y), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    base = log_y.size();
    send('h0100, 12);
    drain();
    check_log("t5", base, 0, 'h0BB, 12, 3);

    // Random traffic with random back-pressure and clears
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 65535));
      else v = int'($urandom_range(0, 6000)) - 3000;
      in_x      = v[IN_W-1:0];
      in_tag    = TAG_W'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 4) != 0);
      clear     = ($urandom_range(0, 63) == 0);
      @(posedge clk);
      #1;
    end
    clear     = 1'b0;
    out_ready = 1'b1;
    drain();

    // Full input sweep in ascending signed order
    prev_y   = -1;
    sweep_on = 1'b1;
    for (int x = -32768; x < 32768; x++) send(x, int'($urandom_range(0, 15)));
    drain();
    sweep_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sigmoid_pipe.md
Name: sigmoid_pipe

Overview:
Parametrised, pipelined successor to the combinational sigmoid lookup. Computes y = sigmoid(x) on signed fixed-point activations. Uses 16-segment piecewise-linear interpolation over |x| in [0,8) and mirrors negative inputs through sigmoid(-x) = 1 - sigmoid(x). Sits between the neuron accumulator and the next layer's input buffer, with a valid/ready handshake, tag pass-through and a saturation counter.

Parameters:
IN_W, 16, input width (signed two's complement); IN_W >= IN_FRAC+5
IN_FRAC, 8, input fraction bits (default Q7.8); IN_FRAC >= 1
OUT_FRAC, 8, output fraction bits; 1.0 = 2^OUT_FRAC; output width = OUT_FRAC+1
TAG_W, 4, width of the sideband tag (neuron/channel id) carried alongside each sample
CNT_W, 16, saturation counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_x  in  IN_W  signed activation
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  OUT_FRAC+1  unsigned sigmoid result
out_tag  out  TAG_W  tag of out_y's sample
clear  in  1  synchronous clear of sat_cnt
sat_cnt  out  CNT_W  number of accepted inputs with |x| >= 8.0

Behaviour:
- Reset (async assert): out_valid = 0, all internal stage valids = 0, out_y = 0, out_tag = 0, sat_cnt = 0. Reset mid-operation drops all in-flight samples; no output for them after release.
- Pipeline stall: en = !out_valid || out_ready. in_ready = en. All stages advance only when en = 1. The whole pipe stalls together (no bubble collapse). Transfer occurs on in_valid && in_ready.
- Out handshake: out_y and out_tag are held stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from input accept to out_valid when out_ready is held high. Throughput is 1 sample/cycle.
- S1: capture sign s = x[MSB]. Compute a = |x| at IN_W+1 bits, so the most negative input is handled without overflow. sat = (a >= 8 << IN_FRAC). idx = a[IN_FRAC+2:IN_FRAC-1] (4 bits, step 0.5). f = a[IN_FRAC-2:0] (IN_FRAC-1 bits).
- S2: fetch T[idx] and D = T[idx+1] - T[idx] (D >= 0). Compute p = D*f at full width.
- S3: compute m = T[idx] + (p >> (IN_FRAC-1)), truncating.
  - If sat: m = 2^OUT_FRAC.
  - Result = s ? 2^OUT_FRAC - m : m. The result is registered into out_y.
- Table: T[k] = round(2^OUT_FRAC * 1/(1+exp(-k/2))) for k = 0..16, computed at elaboration as constants. For OUT_FRAC=8: 128,159,187,209,225,237,244,248,251,253,254,255,255,256,256,256,256.
- Output range: [0, 2^OUT_FRAC]. x=0 yields exactly 2^(OUT_FRAC-1).
- sat_cnt:
  - Increments by 1 on each accepted sample with sat = 1, counted at S1 entry (the accept cycle).
  - Saturates at all-ones and does not wrap.
  - clear forces it to 0 next cycle. clear wins over a simultaneous increment.

Test Plan:
- Reset then stream x = 0x0000, 0x0100, 0xFF00 with out_ready=1 -> out_y = 0x080, 0x0BB, 0x045 on cycles 3, 4, 5 after first accept; tags follow in order.
- x = 0x0040 (0.25) and x = 0xFFC0 (-0.25) -> out_y = 0x08F (143) and 0x071 (113); checks interpolation truncation and mirroring.
- x = 0x0800, 0x7FFF, 0xF800, 0x8000 -> out_y = 0x100, 0x100, 0x000, 0x000; sat_cnt = 4. Then pulse clear coincident with another saturated accept -> sat_cnt = 0.
- Back-pressure: drive out_ready=0 for 5 cycles with in_valid=1 -> in_ready low while out_valid is held. out_y/out_tag stay stable, no sample is lost or duplicated; on release the sequence is in order and complete.
- Assert reset with 3 samples in flight -> out_valid=0 immediately (async). After release, no stale outputs; the next input appears after 3 cycles.
- Sweep all 65536 inputs against the reference model: m from the table equations, monotone non-decreasing in x, |out_y - round(256*sigmoid(x/256))| <= 2.
